uart_imem_loader: RTL and testbench

//  Assembles the UART receiver's byte stream into little-endian instruction words and writes them to instruction memory at consecutive addresses.

---
 rtl/uart_imem_loader_pkg.sv | 24 ++
 rtl/uart_imem_loader_if.sv | 12 +
 rtl/uart_imem_loader_word_asm.sv | 39 +++
 rtl/uart_imem_loader.sv | 129 ++++++++++++
 tb/tb_uart_imem_loader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_imem_loader_pkg.sv
// Shared types and helpers for the UART instruction-memory boot loader.
package uart_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ASSEMBLE,
        WRITE,
        DONE,
        ERROR
    } loader_state_t;

    // All-ones test over the low nbytes bytes of a zero-extended word.
    function automatic logic is_marker(input logic [63:0] word, input int nbytes);
        logic all_ones;
        all_ones = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i < nbytes * BYTE_W) all_ones = all_ones & word[i];
        end
        return all_ones;
    endfunction

endpackage

// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port driven by the loader (master) into the memory (slave).
interface uart_imem_loader_if #(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 32
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    modport master (output mem_we, mem_addr, mem_wdata);
    modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/uart_imem_loader_word_asm.sv
// Little-endian byte lane register: each pushed byte lands in lane byte_idx, lane 0 is the LSB.
module loader_word_asm
    import uart_loader_pkg::*;
#(
    parameter  int WORD_BYTES = 4,
    localparam int WORD_W     = BYTE_W * WORD_BYTES,
    localparam int IDX_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              push,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic [IDX_W-1:0]  byte_idx,
    output logic              word_full
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    // High in the cycle the final lane is being pushed, so the FSM can move on at that edge.
    assign word_full = push && (byte_idx == LAST_IDX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (push) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (byte_idx == IDX_W'(i)) word[i*BYTE_W +: BYTE_W] <= byte_in;
            end
            byte_idx <= word_full ? '0 : byte_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: packs UART bytes into words and writes them to consecutive imem addresses.
// Optional inter-byte timeout is enabled by defining LOADER_TIMEOUT_EN.
module uart_imem_loader
    import uart_loader_pkg::*;
#(
    parameter  int WORD_BYTES  = 4,
    parameter  int DEPTH       = 32,
    parameter  int STOP_MARKER = 1,
    parameter  int TIMEOUT_CYC = 200000,
    localparam int WORD_W      = BYTE_W * WORD_BYTES,
    localparam int ADDR_W      = $clog2(DEPTH),
    localparam int IDX_W       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                load_en,
    input  logic                rx_valid,
    input  logic [BYTE_W-1:0]   rx_data,
    input  logic                rx_break,
    uart_imem_loader_if.master  mem,
    output logic [ADDR_W:0]     word_count,
    output logic                write_done,
    output logic                load_error
);

    localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

    loader_state_t     state;
    logic [WORD_W-1:0] asm_word;
    logic [IDX_W-1:0]  byte_idx;
    logic              word_full;
    logic              push;
    logic              timeout_hit;

    // A byte coinciding with BREAK is dropped: the break wins.
    assign push = (state == ASSEMBLE) && load_en && rx_valid && !rx_break;

    loader_word_asm #(.WORD_BYTES(WORD_BYTES)) u_asm (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (state == IDLE),
        .push      (push),
        .byte_in   (rx_data),
        .word      (asm_word),
        .byte_idx  (byte_idx),
        .word_full (word_full)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_run;

    assign tmo_run     = (state == ASSEMBLE) && (byte_idx != '0) && !rx_valid;
    assign timeout_hit = tmo_run && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      tmo_cnt <= '0;
        else if (tmo_run) tmo_cnt <= tmo_cnt + TMO_W'(1);
        else              tmo_cnt <= '0;
    end
`else
    logic unused_tmo;
    assign timeout_hit = 1'b0;
    assign unused_tmo  = (^byte_idx) ^ (TIMEOUT_CYC != 0);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // The instruction memory itself is never reset here; only loader state clears.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            word_count    <= '0;
            write_done    <= 1'b0;
            load_error    <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            mem.mem_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_en) begin
                        state      <= ASSEMBLE;
                        word_count <= '0;
                        write_done <= 1'b0;
                        load_error <= 1'b0;
                    end
                end
                ASSEMBLE: begin
                    if (!load_en) begin
                        state <= IDLE;
                    end else if (rx_break || timeout_hit) begin
                        state      <= ERROR;
                        load_error <= 1'b1;
                    end else if (word_full) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (!load_en) begin
                        state <= IDLE;
                    end else if (rx_break || rx_valid) begin
                        state      <= ERROR;
                        load_error <= 1'b1;
                    end else if (STOP_MARKER != 0 && is_marker(64'(asm_word), WORD_BYTES)) begin
                        state      <= DONE;
                        write_done <= 1'b1;
                    end else begin
                        mem.mem_we    <= 1'b1;
                        mem.mem_addr  <= word_count[ADDR_W-1:0];
                        mem.mem_wdata <= asm_word;
                        word_count    <= word_count + (ADDR_W + 1)'(1);
                        if (word_count == LAST_COUNT) begin
                            state      <= DONE;
                            write_done <= 1'b1;
                        end else begin
                            state <= ASSEMBLE;
                        end
                    end
                end
                DONE:    if (!load_en) state <= IDLE;
                ERROR:   if (!load_en) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench: default loader (A) and a DEPTH=4, no-marker loader (B) sharing clk/resetn.
module tb_uart_imem_loader;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic       clk;
    logic       resetn;
    logic       a_load_en, a_rx_valid, a_rx_break;
    logic [7:0] a_rx_data;
    logic       b_load_en, b_rx_valid, b_rx_break;
    logic [7:0] b_rx_data;
    logic [5:0] a_word_count;
    logic [2:0] b_word_count;
    logic       a_write_done, a_load_error, b_write_done, b_load_error;

    int  checks = 0;
    int  errors = 0;
    wr_t a_writes[$];
    wr_t b_writes[$];
    logic [31:0] b_words [0:4];

    uart_imem_loader_if #(.ADDR_W(5), .WORD_W(32)) a_mem ();
    uart_imem_loader_if #(.ADDR_W(2), .WORD_W(32)) b_mem ();

    uart_imem_loader #(.WORD_BYTES(4), .DEPTH(32), .STOP_MARKER(1), .TIMEOUT_CYC(100)) dut_a (
        .clk        (clk),
        .resetn     (resetn),
        .load_en    (a_load_en),
        .rx_valid   (a_rx_valid),
        .rx_data    (a_rx_data),
        .rx_break   (a_rx_break),
        .mem        (a_mem.master),
        .word_count (a_word_count),
        .write_done (a_write_done),
        .load_error (a_load_error)
    );

    uart_imem_loader #(.WORD_BYTES(4), .DEPTH(4), .STOP_MARKER(0), .TIMEOUT_CYC(100)) dut_b (
        .clk        (clk),
        .resetn     (resetn),
        .load_en    (b_load_en),
        .rx_valid   (b_rx_valid),
        .rx_data    (b_rx_data),
        .rx_break   (b_rx_break),
        .mem        (b_mem.master),
        .word_count (b_word_count),
        .write_done (b_write_done),
        .load_error (b_load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn && a_mem.mem_we) a_writes.push_back('{8'(a_mem.mem_addr), a_mem.mem_wdata});
        if (resetn && b_mem.mem_we) b_writes.push_back('{8'(b_mem.mem_addr), b_mem.mem_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s mismatch", tag);
        end
    endtask

    task automatic send_byte(input bit sel_b, input logic [7:0] d);
        @(negedge clk);
        if (sel_b) begin
            b_rx_valid = 1'b1;
            b_rx_data  = d;
        end else begin
            a_rx_valid = 1'b1;
            a_rx_data  = d;
        end
        @(negedge clk);
        a_rx_valid = 1'b0;
        b_rx_valid = 1'b0;
    endtask

    task automatic send_word(input bit sel_b, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(sel_b, w[i*8 +: 8]);
            if (i < 3) repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        b_words[0] = 32'hfe01_0113;
        b_words[1] = 32'h0081_2e23;
        b_words[2] = 32'h1234_5678;
        b_words[3] = 32'hffff_ffff;
        b_words[4] = 32'hdead_beef;
        resetn = 1'b0;
        a_load_en = 1'b0; a_rx_valid = 1'b0; a_rx_break = 1'b0; a_rx_data = 8'h00;
        b_load_en = 1'b0; b_rx_valid = 1'b0; b_rx_break = 1'b0; b_rx_data = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_we",    a_mem.mem_we, 0);
        check("rst_addr",  a_mem.mem_addr, 0);
        check("rst_wdata", a_mem.mem_wdata, 0);
        check("rst_count", a_word_count, 0);
        check("rst_done",  a_write_done, 0);
        check("rst_err",   a_load_error, 0);
        resetn = 1'b1;

        // 1: one word then the all-ones marker
        a_load_en = 1'b1;
        repeat (2) @(negedge clk);
        send_word(0, 32'hfe01_0113);
        check("t1_we_early", a_mem.mem_we, 0);
        @(negedge clk);
        check("t1_we",    a_mem.mem_we, 1);
        check("t1_addr",  a_mem.mem_addr, 0);
        check("t1_wdata", a_mem.mem_wdata, 32'hfe01_0113);
        check("t1_count", a_word_count, 1);
        @(negedge clk);
        check("t1_we_pulse", a_mem.mem_we, 0);
        send_word(0, 32'hffff_ffff);
        repeat (3) @(negedge clk);
        check("t1_done",   a_write_done, 1);
        check("t1_count2", a_word_count, 1);
        check("t1_writes", a_writes.size(), 1);
        send_word(0, 32'h1234_5678);
        repeat (3) @(negedge clk);
        check("t1_ignored", a_writes.size(), 1);
        a_load_en = 1'b0;
        repeat (2) @(negedge clk);
        check("t1_done_kept", a_write_done, 1);

        // 3: break mid-word
        a_load_en = 1'b1;
        repeat (2) @(negedge clk);
        check("t3_done_clr", a_write_done, 0);
        check("t3_count_clr", a_word_count, 0);
        send_byte(0, 8'haa);
        repeat (3) @(negedge clk);
        send_byte(0, 8'hbb);
        repeat (3) @(negedge clk);
        a_rx_break = 1'b1;
        @(negedge clk);
        a_rx_break = 1'b0;
        repeat (4) @(negedge clk);
        check("t3_err",    a_load_error, 1);
        check("t3_done",   a_write_done, 0);
        check("t3_writes", a_writes.size(), 1);
        a_load_en = 1'b0;
        repeat (2) @(negedge clk);

        // 4: load_en drop discards a partial word
        a_load_en = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(0, 8'h11);
        send_byte(0, 8'h22);
        send_byte(0, 8'h33);
        a_load_en = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_no_err", a_load_error, 0);
        a_load_en = 1'b1;
        repeat (2) @(negedge clk);
        send_word(0, 32'h0081_2e23);
        @(negedge clk);
        check("t4_we",    a_mem.mem_we, 1);
        check("t4_addr",  a_mem.mem_addr, 0);
        check("t4_wdata", a_mem.mem_wdata, 32'h0081_2e23);
        @(negedge clk);
        check("t4_writes", a_writes.size(), 2);

        // 6: inter-byte timeout
        send_byte(0, 8'h44);
        repeat (105) @(negedge clk);
`ifdef LOADER_TIMEOUT_EN
        check("t6_tmo_err", a_load_error, 1);
        check("t6_tmo_nowr", a_writes.size(), 2);
        a_load_en = 1'b0;
        repeat (2) @(negedge clk);
        a_load_en = 1'b1;
        repeat (2) @(negedge clk);
`else
        check("t6_no_err", a_load_error, 0);
        send_byte(0, 8'h55);
        send_byte(0, 8'h66);
        send_byte(0, 8'h77);
        @(negedge clk);
        check("t6_we",    a_mem.mem_we, 1);
        check("t6_addr",  a_mem.mem_addr, 1);
        check("t6_wdata", a_mem.mem_wdata, 32'h7766_5544);
`endif

        // 2: DEPTH limit without marker on loader B
        b_load_en = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            send_word(1, b_words[k]);
            repeat (2) @(negedge clk);
            if (k == 2) check("t2_not_done", b_write_done, 0);
        end
        check("t2_done",  b_write_done, 1);
        check("t2_count", b_word_count, 4);
        send_word(1, b_words[4]);
        repeat (3) @(negedge clk);
        check("t2_writes", b_writes.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_addr%0d", k), b_writes[k].addr, k);
            check($sformatf("t2_data%0d", k), b_writes[k].data, b_words[k]);
        end

        // 5: asynchronous reset mid-word
        send_byte(0, 8'h99);
        send_byte(0, 8'h88);
        #2 resetn = 1'b0;
        #1;
        check("t5_addr",   a_mem.mem_addr, 0);
        check("t5_wdata",  a_mem.mem_wdata, 0);
        check("t5_count",  a_word_count, 0);
        check("t5_b_done", b_write_done, 0);
        check("t5_b_count", b_word_count, 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        send_word(0, 32'ha5a5_0001);
        @(negedge clk);
        check("t5_we",    a_mem.mem_we, 1);
        check("t5_addr2", a_mem.mem_addr, 0);
        check("t5_data2", a_mem.mem_wdata, 32'ha5a5_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
